// File: rtl/matrix_result_unloader.sv
// Streams product matrix C out of the shared RAM in row-major order over valid/ready.
// Optional running checksum output enabled by UNLOAD_CHKSUM_EN.
module matrix_result_unloader #(
    parameter int unsigned data_w    = 32,
    parameter int unsigned ram_d     = 512,
    parameter int unsigned ram_add_w = $clog2(ram_d),
    parameter int unsigned d_w_q     = data_w / 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ram_add_w-1:0] ram_addr,
    input  logic [data_w-1:0]    ram_r_data,
    output logic [data_w-1:0]    m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_row_last,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef UNLOAD_CHKSUM_EN
    ,
    output logic [data_w-1:0]    chksum
`endif
);

    localparam int unsigned prod_w = 2 * d_w_q + 1;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHECK, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [ram_add_w-1:0] addr_q, addr_d;
    logic [d_w_q-1:0]     m1_q, m1_d, n2_q, n2_d, i_q, i_d, j_q, j_d;
    logic                 odd_q, odd_d;
    logic                 err_q, err_d, busy_q, busy_d, done_q, done_d;
    logic                 inf_q, inf_d, inf_rl_q, inf_rl_d, inf_l_q, inf_l_d;
    logic [data_w-1:0]    hd_data_q, hd_data_d, sk_data_q, sk_data_d;
    logic                 hd_v_q, hd_v_d, hd_rl_q, hd_rl_d, hd_l_q, hd_l_d;
    logic                 sk_v_q, sk_v_d, sk_rl_q, sk_rl_d, sk_l_q, sk_l_d;

    logic [d_w_q-1:0]     hdr_m1, hdr_n2;
    logic [d_w_q:0]       hdr_wp;
    logic [prod_w-1:0]    footprint;
    logic                 hdr_bad, pop, credit_ok, issue, cur_rl, cur_l;
    logic [1:0]           occ;

    // Header decode and footprint range check
    assign hdr_m1    = ram_r_data[data_w-1 -: d_w_q];
    assign hdr_n2    = ram_r_data[d_w_q-1:0];
    assign hdr_wp    = (d_w_q+1)'(hdr_n2) + (d_w_q+1)'(hdr_n2[0]);
    assign footprint = prod_w'(hdr_m1) * prod_w'(hdr_wp);
    assign hdr_bad   = (hdr_m1 == '0) || (hdr_n2 == '0) || (footprint > prod_w'(ram_d - 2));

    // A pop this cycle frees a slot, so the issue credit counts occupancy after the pop
    assign pop       = hd_v_q & m_ready;
    assign occ       = 2'(hd_v_q) + 2'(sk_v_q);
    assign credit_ok = (occ - 2'(pop) + 2'(inf_q)) < 2'd2;
    assign issue     = (state_q == S_STREAM) && credit_ok;
    assign cur_rl    = (j_q == n2_q - d_w_q'(1));
    assign cur_l     = cur_rl && (i_q == m1_q - d_w_q'(1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        m1_d      = m1_q;
        n2_d      = n2_q;
        odd_d     = odd_q;
        i_d       = i_q;
        j_d       = j_q;
        err_d     = err_q;
        inf_d     = 1'b0;
        inf_rl_d  = inf_rl_q;
        inf_l_d   = inf_l_q;
        hd_data_d = hd_data_q;
        hd_v_d    = hd_v_q;
        hd_rl_d   = hd_rl_q;
        hd_l_d    = hd_l_q;
        sk_data_d = sk_data_q;
        sk_v_d    = sk_v_q;
        sk_rl_d   = sk_rl_q;
        sk_l_d    = sk_l_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_HDR: state_d = S_CHECK;
            S_CHECK: begin
                m1_d  = hdr_m1;
                n2_d  = hdr_n2;
                odd_d = hdr_n2[0];
                i_d   = '0;
                j_d   = '0;
                if (hdr_bad) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STREAM;
                    addr_d  = ram_add_w'(ram_d - 1);
                end
            end
            S_STREAM: begin
                if (issue) begin
                    inf_d    = 1'b1;
                    inf_rl_d = cur_rl;
                    inf_l_d  = cur_l;
                    if (cur_rl) begin
                        j_d    = '0;
                        i_d    = i_q + d_w_q'(1);
                        addr_d = addr_q - ram_add_w'(odd_q) - ram_add_w'(1);
                    end else begin
                        j_d    = j_q + d_w_q'(1);
                        addr_d = addr_q - ram_add_w'(1);
                    end
                    if (cur_l) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inf_q && !sk_v_q && (!hd_v_q || pop)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Two-entry skid: head drives the stream, skid catches data arriving during a stall
        if (!hd_v_q || pop) begin
            if (sk_v_q) begin
                hd_data_d = sk_data_q;
                hd_rl_d   = sk_rl_q;
                hd_l_d    = sk_l_q;
                hd_v_d    = 1'b1;
                sk_v_d    = inf_q;
                sk_rl_d   = inf_q & inf_rl_q;
                sk_l_d    = inf_q & inf_l_q;
                if (inf_q) sk_data_d = ram_r_data;
            end else begin
                hd_v_d  = inf_q;
                hd_rl_d = inf_q & inf_rl_q;
                hd_l_d  = inf_q & inf_l_q;
                if (inf_q) hd_data_d = ram_r_data;
            end
        end else if (inf_q) begin
            sk_v_d    = 1'b1;
            sk_data_d = ram_r_data;
            sk_rl_d   = inf_rl_q;
            sk_l_d    = inf_l_q;
        end

        busy_d = (state_d == S_HDR) || (state_d == S_CHECK) ||
                 (state_d == S_STREAM) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            m1_q      <= '0;
            n2_q      <= '0;
            odd_q     <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            inf_q     <= 1'b0;
            inf_rl_q  <= 1'b0;
            inf_l_q   <= 1'b0;
            hd_data_q <= '0;
            hd_v_q    <= 1'b0;
            hd_rl_q   <= 1'b0;
            hd_l_q    <= 1'b0;
            sk_data_q <= '0;
            sk_v_q    <= 1'b0;
            sk_rl_q   <= 1'b0;
            sk_l_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            m1_q      <= m1_d;
            n2_q      <= n2_d;
            odd_q     <= odd_d;
            i_q       <= i_d;
            j_q       <= j_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            inf_q     <= inf_d;
            inf_rl_q  <= inf_rl_d;
            inf_l_q   <= inf_l_d;
            hd_data_q <= hd_data_d;
            hd_v_q    <= hd_v_d;
            hd_rl_q   <= hd_rl_d;
            hd_l_q    <= hd_l_d;
            sk_data_q <= sk_data_d;
            sk_v_q    <= sk_v_d;
            sk_rl_q   <= sk_rl_d;
            sk_l_q    <= sk_l_d;
        end
    end

    assign ram_addr   = addr_q;
    assign m_data     = hd_data_q;
    assign m_valid    = hd_v_q;
    assign m_row_last = hd_rl_q;
    assign m_last     = hd_l_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

`ifdef UNLOAD_CHKSUM_EN
    logic [data_w-1:0] chksum_q;

    // Running sum of accepted beats, restarted by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            chksum_q <= '0;
        end else if (pop) begin
            chksum_q <= chksum_q + hd_data_q;
        end
    end

    assign chksum = chksum_q;
`else
    // No checksum port in this build
`endif

endmodule

// File: tb/tb_matrix_result_unloader.sv
// Randomized self-checking bench for matrix_result_unloader against a row-major reference model.
// Checksum checks are compiled in with UNLOAD_CHKSUM_EN.
module tb_matrix_result_unloader;

    localparam int unsigned DW = 32;
    localparam int unsigned RD = 512;
    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_r_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_row_last;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err;
`ifdef UNLOAD_CHKSUM_EN
    logic [DW-1:0] chksum;
`endif

    logic [DW-1:0] mem [RD];
    int checks = 0;
    int errors = 0;

    matrix_result_unloader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ram_addr   (ram_addr),
        .ram_r_data (ram_r_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_row_last (m_row_last),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef UNLOAD_CHKSUM_EN
        ,
        .chksum     (chksum)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, one cycle latency
    always @(posedge clk) ram_r_data <= mem[ram_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic bit ready_at(input int mode, input int cyc);
        int pat[7];
        pat = '{1, 0, 0, 1, 0, 1, 1};
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[cyc % 7] == 1;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic check_reset_outs(input string tag);
        check(tag, {ram_addr, m_valid, m_row_last, m_last, busy, done, err}, 64'd0);
        check({tag, "_data"}, m_data, 64'd0);
`ifdef UNLOAD_CHKSUM_EN
        check({tag, "_chksum"}, chksum, 64'd0);
`endif
    endtask

    // One unload: model builds the expected beat list from header and RAM contents.
    task automatic run_unload(input logic [31:0] hdr, input int mode, input int abort_after,
                              input bit poke_start);
        logic [33:0] exp_q[$];
        logic [33:0] prev;
        logic [31:0] sum;
        logic [31:0] ck;
        int m1, n2, wp, total, nb, budget;
        bit exp_err, got_done, stall;
        m1 = int'(hdr[31:24]);
        n2 = int'(hdr[7:0]);
        wp = n2 + (n2 % 2);
        exp_err = (m1 == 0) || (n2 == 0) || (m1 * wp > int'(RD) - 2);
        sum = '0;
        ck = '0;
        nb = 0;
        got_done = 1'b0;
        stall = 1'b0;
        prev = '0;
        if (!exp_err) begin
            for (int i = 0; i < m1; i++) begin
                for (int j = 0; j < n2; j++) begin
                    int a;
                    bit rl, l;
                    a  = int'(RD) - 1 - i * wp - j;
                    rl = (j == n2 - 1);
                    l  = rl && (i == m1 - 1);
                    exp_q.push_back({mem[a], rl, l});
                    sum += mem[a];
                end
            end
        end
        total = exp_q.size();
        mem[0] = hdr;
        @(posedge clk);
        #1 start = 1'b1;
        m_ready = ready_at(mode, 0);
        @(posedge clk);
        #1 start = 1'b0;
        budget = exp_err ? 30 : total * 8 + 40;
        for (int cyc = 1; cyc < budget && !got_done; cyc++) begin
            @(negedge clk);
            if (stall) check("hold", {m_valid, m_data, m_row_last, m_last}, {1'b1, prev});
            stall = m_valid && !m_ready;
            prev  = {m_data, m_row_last, m_last};
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("extra_beat", 64'(nb + 1), 64'(total));
                else check("beat", {m_data, m_row_last, m_last}, exp_q.pop_front());
                nb++;
                if (nb == abort_after) begin
                    #2 rst_n = 1'b0;
                    #1 check_reset_outs("async_rst");
                    @(posedge clk);
                    #1 rst_n = 1'b1;
                    return;
                end
            end
            if (done) begin
                got_done = 1'b1;
`ifdef UNLOAD_CHKSUM_EN
                ck = chksum;
`endif
            end
            @(posedge clk);
            #1 m_ready = ready_at(mode, cyc);
            start = poke_start && (cyc == 4);
        end
        start = 1'b0;
        check("done_seen", 64'(got_done), 64'(!exp_err));
        check("beats_left", 64'(exp_q.size()), 64'd0);
        check("beat_count", 64'(nb), 64'(total));
        check("err", err, 64'(exp_err));
        check("busy_end", busy, 64'd0);
`ifdef UNLOAD_CHKSUM_EN
        if (!exp_err) check("chksum", ck, sum);
`endif
        if (ck != '0 && exp_err) check("chksum_on_err", ck, 64'd0);
    endtask

    task automatic load_t1();
        mem[511] = 32'd1;
        mem[510] = 32'd2;
        mem[509] = 32'd3;
        mem[508] = 32'd4;
    endtask

    task automatic load_t2();
        logic [31:0] v;
        v = 32'd1;
        for (int a = 511; a >= 501; a--) begin
            if (a == 508 || a == 504) mem[a] = 32'hBAD0_0000 | 32'(a);
            else begin
                mem[a] = v;
                v++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        m_ready = 1'b0;
        for (int a = 0; a < int'(RD); a++) mem[a] = '0;
        #12 check_reset_outs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        load_t1();
        run_unload(32'h0203_0302, 0, -1, 1'b0);
        load_t2();
        run_unload(32'h0302_0203, 0, -1, 1'b0);
        load_t1();
        run_unload(32'h0203_0302, 1, -1, 1'b1);
        run_unload(32'h0003_0302, 0, -1, 1'b0);
        run_unload(32'h2020_2020, 0, -1, 1'b0);
        run_unload(32'h0203_0302, 0, -1, 1'b0);
        load_t2();
        run_unload(32'h0302_0203, 0, 2, 1'b0);
        run_unload(32'h0302_0203, 0, -1, 1'b0);

        for (int a = 0; a < int'(RD); a++) mem[a] = $urandom;
        run_unload(32'h0111_1101, 2, -1, 1'b0);
        run_unload(32'h0122_2205, 1, -1, 1'b0);
        run_unload(32'h0533_3301, 2, -1, 1'b0);
        run_unload(32'h01FF_FFFF, 0, -1, 1'b0);

        for (int t = 0; t < 24; t++) begin
            logic [31:0] hdr;
            for (int a = 1; a < int'(RD); a++) mem[a] = $urandom;
            hdr = {8'($urandom_range(0, 12)), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 40))};
            run_unload(hdr, int'($urandom_range(0, 2)), -1, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
